// File: rtl/keccak_squeeze.sv
// Keccak squeeze stage: streams digest bytes from the rate part of the state and requests permutations between blocks.
// Optional macro KECCAK_SQUEEZE_VARLEN_EN adds an out_len port that replaces the fixed OUT_BITS/8 length.
module keccak_squeeze #(
    parameter int STATE_BITS = 1600,
    parameter int RATE_BITS  = 1088,
    parameter int OUT_BITS   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [STATE_BITS-1:0] state_in,
    output logic                  perm_req,
    output logic [STATE_BITS-1:0] perm_state_out,
    input  logic                  perm_ack,
    input  logic [STATE_BITS-1:0] perm_state_in,
    output logic [7:0]            dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  done
`ifdef KECCAK_SQUEEZE_VARLEN_EN
    ,
    input  logic [15:0]           out_len
`endif
);

    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int OUT_BYTES  = OUT_BITS / 8;
    localparam int IDX_W      = $clog2(RATE_BYTES + 1);
`ifdef KECCAK_SQUEEZE_VARLEN_EN
    localparam int CNT_W      = 16;
`else
    localparam int CNT_W      = $clog2(OUT_BYTES + 1);
`endif

    typedef enum logic [1:0] {IDLE, EMIT, PERMUTE, DONE_STATE} fsm_t;

    fsm_t                  fsm;
    logic [STATE_BITS-1:0] state_q;
    logic [IDX_W-1:0]      rate_idx;
    logic [IDX_W-1:0]      idx_inc;
    logic [CNT_W-1:0]      out_cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      byte_limit;
    logic                  last_byte;
    logic                  rate_end;
    logic                  zero_len;
    logic [7:0]            next_byte;

`ifdef KECCAK_SQUEEZE_VARLEN_EN
    logic [CNT_W-1:0]      len_q;
    assign byte_limit = len_q;
    assign zero_len   = (out_len == 16'd0);
`else
    assign byte_limit = CNT_W'(OUT_BYTES);
    assign zero_len   = 1'b0;
`endif

    assign perm_state_out = state_q;
    assign idx_inc        = rate_idx + IDX_W'(1);
    assign cnt_inc        = out_cnt + CNT_W'(1);
    assign last_byte      = (cnt_inc == byte_limit);
    assign rate_end       = (idx_inc == IDX_W'(RATE_BYTES));
    // Index RATE_BYTES still lies inside the state, so this select is always in range.
    assign next_byte      = state_q[8*int'(idx_inc) +: 8];

    // NOTE: outputs are registered next to the state, so every branch sets
    // them to the values the destination state must present.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            state_q    <= '0;
            rate_idx   <= '0;
            out_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            perm_req   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef KECCAK_SQUEEZE_VARLEN_EN
            len_q      <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (start) begin
                        state_q  <= state_in;
                        rate_idx <= '0;
                        out_cnt  <= '0;
                        busy     <= 1'b1;
`ifdef KECCAK_SQUEEZE_VARLEN_EN
                        len_q    <= out_len;
`endif
                        if (zero_len) begin
                            fsm  <= DONE_STATE;
                            done <= 1'b1;
                        end else begin
                            fsm        <= EMIT;
                            dout_valid <= 1'b1;
                            dout       <= state_in[7:0];
                        end
                    end
                end
                EMIT: begin
                    if (dout_ready) begin
                        rate_idx <= idx_inc;
                        out_cnt  <= cnt_inc;
                        // Finishing wins over block exhaustion: no permutation after the last byte.
                        if (last_byte) begin
                            fsm        <= DONE_STATE;
                            dout_valid <= 1'b0;
                            dout       <= '0;
                            done       <= 1'b1;
                        end else if (rate_end) begin
                            fsm        <= PERMUTE;
                            dout_valid <= 1'b0;
                            dout       <= '0;
                            perm_req   <= 1'b1;
                        end else begin
                            dout <= next_byte;
                        end
                    end
                end
                PERMUTE: begin
                    if (perm_ack) begin
                        state_q    <= perm_state_in;
                        rate_idx   <= '0;
                        fsm        <= EMIT;
                        perm_req   <= 1'b0;
                        dout_valid <= 1'b1;
                        dout       <= perm_state_in[7:0];
                    end
                end
                DONE_STATE: begin
                    fsm  <= IDLE;
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_squeeze.sv
// Self-checking bench for keccak_squeeze: directed vector table, reset/abort sequence and randomized runs against a byte-stream model.
// Define KECCAK_SQUEEZE_VARLEN_EN for both files to exercise the out_len variant.
module tb_keccak_squeeze;

    localparam int STATE_BITS = 64;
    localparam int RATE_BITS  = 32;
    localparam int OUT_BITS   = 48;
    localparam int RATE_BYTES = RATE_BITS / 8;
    localparam int OUT_BYTES  = OUT_BITS / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [STATE_BITS-1:0] state_in;
    logic                  perm_req;
    logic [STATE_BITS-1:0] perm_state_out;
    logic                  perm_ack;
    logic [STATE_BITS-1:0] perm_state_in;
    logic [7:0]            dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  busy;
    logic                  done;
`ifdef KECCAK_SQUEEZE_VARLEN_EN
    logic [15:0]           out_len = 16'd6;
`endif

    int checks = 0;
    int errors = 0;

    keccak_squeeze #(
        .STATE_BITS(STATE_BITS),
        .RATE_BITS (RATE_BITS),
        .OUT_BITS  (OUT_BITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .state_in      (state_in),
        .perm_req      (perm_req),
        .perm_state_out(perm_state_out),
        .perm_ack      (perm_ack),
        .perm_state_in (perm_state_in),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready),
        .busy          (busy),
        .done          (done)
`ifdef KECCAK_SQUEEZE_VARLEN_EN
        ,
        .out_len       (out_len)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  st;
        logic [63:0]  ps;
        int           ack_delay;
        int           stall_idx;
        int           stall_len;
        bit           glitch;
        logic [127:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Digest byte k comes from block k/RATE_BYTES: block 0 is the absorbed
    // state, every later block is whatever the permutation unit returned.
    function automatic logic [127:0] model_bytes(input logic [63:0] st, input logic [63:0] ps, input int n);
        logic [127:0] r;
        logic [63:0]  blk;
        r = '0;
        for (int k = 0; k < n; k++) begin
            blk = (k < RATE_BYTES) ? st : ps;
            r[8*k +: 8] = blk[8*(k % RATE_BYTES) +: 8];
        end
        return r;
    endfunction

    task automatic run_squeeze(input string tag, input logic [63:0] st, input logic [63:0] ps,
                               input int n, input int ack_delay, input int stall_idx,
                               input int stall_len, input bit glitch, input logic [127:0] exp);
        int got, perm_seen, perm_cyc, stall_cnt, last_cyc;
        bit fin, glitched;
        got = 0; perm_seen = 0; perm_cyc = 0; stall_cnt = 0; last_cyc = -1;
        fin = 0; glitched = 0;
`ifdef KECCAK_SQUEEZE_VARLEN_EN
        out_len = 16'(n);
`endif
        @(negedge clk);
        start = 1'b1; state_in = st; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; state_in = ~st;
        check({tag, "_first_valid"}, 64'(dout_valid), (n > 0) ? 64'd1 : 64'd0);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            start = 1'b0; perm_ack = 1'b0;
            check({tag, "_busy"}, 64'(busy), 64'd1);
            if (done) begin
                check({tag, "_bytes"}, 64'(got), 64'(n));
                check({tag, "_perm_count"}, 64'(perm_seen), (n > 0) ? 64'((n - 1) / RATE_BYTES) : 64'd0);
                check({tag, "_done_latency"}, 64'(cyc - last_cyc), 64'd1);
                check({tag, "_done_no_valid"}, 64'(dout_valid), 64'd0);
                fin = 1;
            end else if (dout_valid) begin
                if (perm_cyc != 0) begin
                    check({tag, "_perm_cycles"}, 64'(perm_cyc), 64'(ack_delay));
                    perm_cyc = 0;
                end
                if (got == stall_idx && stall_cnt < stall_len) begin
                    dout_ready = 1'b0;
                    check({tag, "_stall_hold"}, 64'(dout), 64'(exp[8*got +: 8]));
                    stall_cnt++;
                end else begin
                    dout_ready = 1'b1;
                    check({tag, "_byte"}, 64'(dout), 64'(exp[8*got +: 8]));
                    got++;
                    last_cyc = cyc;
                    if (glitch && got == 2 && !glitched) begin
                        start = 1'b1; state_in = ~st; glitched = 1;
                    end
                end
                if ($urandom_range(0, 3) == 0) begin
                    perm_ack = 1'b1; perm_state_in = ~ps;
                end
            end else if (perm_req) begin
                check({tag, "_perm_no_valid"}, 64'(dout_valid), 64'd0);
                if (perm_cyc == 0) begin
                    perm_seen++;
                    check({tag, "_perm_state_out"}, perm_state_out, (perm_seen == 1) ? st : ps);
                end
                perm_cyc++;
                if (perm_cyc == ack_delay) begin
                    perm_ack = 1'b1; perm_state_in = ps;
                end
            end else begin
                checks++; errors++;
                $display("FAIL %s_gap: busy=%0b with no valid, perm_req or done", tag, busy);
            end
            if (!fin) @(negedge clk);
        end
        start = 1'b0; perm_ack = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d bytes, no done", tag, got);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        logic [63:0] st, ps;
        int n;

        rst = 1'b1; start = 1'b0; state_in = '0; perm_ack = 1'b0;
        perm_state_in = '0; dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_perm_req", 64'(perm_req), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_perm_state_out", perm_state_out, 64'd0);

        // basic stream, 5-cycle stall on byte 1, 10-cycle ack delay, start during EMIT
        vecs[0] = '{64'h0123456789ABCDEF, 64'h1111111122223344, 1, -1, 0, 1'b0, 128'h334489ABCDEF};
        vecs[1] = '{64'h0123456789ABCDEF, 64'h1111111122223344, 1,  1, 5, 1'b0, 128'h334489ABCDEF};
        vecs[2] = '{64'h0123456789ABCDEF, 64'h1111111122223344, 10, -1, 0, 1'b0, 128'h334489ABCDEF};
        vecs[3] = '{64'h0123456789ABCDEF, 64'h1111111122223344, 2, -1, 0, 1'b1, 128'h334489ABCDEF};
        for (int i = 0; i < 4; i++) begin
            run_squeeze($sformatf("vec%0d", i), vecs[i].st, vecs[i].ps, OUT_BYTES,
                        vecs[i].ack_delay, vecs[i].stall_idx, vecs[i].stall_len,
                        vecs[i].glitch, vecs[i].exp);
        end

        // reset while waiting for the permutation, then a clean restart
`ifdef KECCAK_SQUEEZE_VARLEN_EN
        out_len = 16'd6;
`endif
        @(negedge clk);
        start = 1'b1; state_in = 64'hFEDCBA9876543210; dout_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !perm_req; c++) @(negedge clk);
        check("abort_reach_permute", 64'(perm_req), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_perm_req", 64'(perm_req), 64'd0);
        check("abort_dout_valid", 64'(dout_valid), 64'd0);
        check("abort_state_clear", perm_state_out, 64'd0);
        st = 64'h0011223344556677;
        ps = 64'h8899AABBCCDDEEFF;
        run_squeeze("restart", st, ps, OUT_BYTES, 3, -1, 0, 1'b0, model_bytes(st, ps, OUT_BYTES));

`ifdef KECCAK_SQUEEZE_VARLEN_EN
        st = 64'h0123456789ABCDEF;
        ps = 64'h1111111122223344;
        run_squeeze("len4", st, ps, 4, 1, -1, 0, 1'b0, model_bytes(st, ps, 4));
        run_squeeze("len0", st, ps, 0, 1, -1, 0, 1'b0, model_bytes(st, ps, 0));
`endif

        for (int i = 0; i < 8; i++) begin
            st = {$urandom, $urandom};
            ps = {$urandom, $urandom};
`ifdef KECCAK_SQUEEZE_VARLEN_EN
            n = int'($urandom_range(0, 12));
`else
            n = OUT_BYTES;
`endif
            run_squeeze($sformatf("rand%0d", i), st, ps, n, int'($urandom_range(1, 6)),
                        int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), model_bytes(st, ps, n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
